// File: rtl/vetris_pkg.sv
// Shared types for the board special-instruction path: op encodings and sequencer states.
package vetris_pkg;

    localparam int unsigned RF_AW = 5;
    localparam int unsigned RF_DW = 32;
    localparam logic [RF_AW-1:0] LINE_STATUS_REG = 5'd9;

    typedef enum logic [1:0] {
        OP_GET_ROW    = 2'b00,
        OP_SEND_ROW   = 2'b01,
        OP_LINE_CHECK = 2'b10,
        OP_RSVD       = 2'b11
    } op_type_e;

    // Also consumed by hazard_detection to decide when to stall.
    typedef enum logic [2:0] {
        IDLE,
        GET_RD,
        GET_WB,
        SEND,
        SCAN,
        LS_WB
    } state_e;

endpackage

// File: rtl/board_row_ctrl_if.sv
// Bundle of EX request, board RAM and register-file write signals around board_row_ctrl.
interface board_row_ctrl_if
    import vetris_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned ROW_W  = 32
);
    logic              op_valid;
    op_type_e          op_type;
    logic [ADDR_W-1:0] op_row;
    logic [ROW_W-1:0]  op_wdata;
    logic [RF_AW-1:0]  op_rd;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [ROW_W-1:0]  mem_wdata;
    logic [ROW_W-1:0]  mem_rdata;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [RF_DW-1:0]  rf_wdata;

    modport master (
        input  op_valid, op_type, op_row, op_wdata, op_rd, mem_rdata,
        output busy, done, mem_addr, mem_re, mem_we, mem_wdata, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        output op_valid, op_type, op_row, op_wdata, op_rd, mem_rdata,
        input  busy, done, mem_addr, mem_re, mem_we, mem_wdata, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/row_full_scanner.sv
// Row index counter plus one-cycle-late full-row compare that accumulates the lineCheck bitmap.
module row_full_scanner #(
    parameter int unsigned     ROWS      = 20,
    parameter int unsigned     ROW_W     = 32,
    parameter int unsigned     ADDR_W    = 5,
    parameter logic [ROW_W-1:0] FULL_MASK = ROW_W'(32'h0000_03FF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] rdata,
    output logic [ROWS-1:0]  bitmap,
    output logic             last
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS - 1);

    logic              reading;
    logic              cmp_vld;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] cmp_idx;
    logic [ROWS-1:0]   acc;
    logic              row_full;

    assign row_full = &(rdata | ~FULL_MASK);
    assign last     = reading && (rd_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reading <= 1'b0;
            cmp_vld <= 1'b0;
            rd_idx  <= '0;
            cmp_idx <= '0;
            acc     <= '0;
        end else begin
            cmp_vld <= reading;
            cmp_idx <= rd_idx;
            if (cmp_vld) acc[cmp_idx] <= row_full;
            if (start) begin
                reading <= 1'b1;
                rd_idx  <= '0;
                acc     <= '0;
            end else if (reading) begin
                if (rd_idx == LAST_IDX) reading <= 1'b0;
                else                    rd_idx  <= rd_idx + ADDR_W'(1);
            end
        end
    end

    // The final row's data arrives in the write-back cycle, so fold it in combinationally.
    always_comb begin
        bitmap = acc;
        if (cmp_vld) bitmap[cmp_idx] = row_full;
    end
endmodule

// File: rtl/board_row_ctrl.sv
// Multi-cycle sequencer for getRow / sendRow / lineCheck; owns board RAM and writes results to the RF.
module board_row_ctrl
    import vetris_pkg::*;
#(
    parameter int unsigned      ROWS      = 20,
    parameter int unsigned      ROW_W     = 32,
    parameter int unsigned      ADDR_W    = 5,
    parameter logic [ROW_W-1:0] FULL_MASK = ROW_W'(32'h0000_03FF)
) (
    input  logic             clk,
    input  logic             rst_n,
    board_row_ctrl_if.master bus
);
    localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

    state_e            state, state_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              mem_re_q, mem_re_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [ROW_W-1:0]  mem_wdata_q, mem_wdata_nxt;
    logic              rf_we_q, rf_we_nxt;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_nxt;
    logic [RF_AW-1:0]  op_rd_q, op_rd_nxt;
    logic              row_ok_q, row_ok_nxt;

    logic              accept;
    logic              row_in_range;
    logic              scan_start;
    logic              scan_last;
    logic [ROWS-1:0]   scan_bitmap;
    logic [RF_DW-1:0]  rf_wdata_c;

    assign accept       = bus.op_valid && (state == IDLE) && (bus.op_type != OP_RSVD);
    assign row_in_range = {1'b0, bus.op_row} < ROWS_L;
    assign scan_start   = accept && (bus.op_type == OP_LINE_CHECK);

    row_full_scanner #(
        .ROWS      (ROWS),
        .ROW_W     (ROW_W),
        .ADDR_W    (ADDR_W),
        .FULL_MASK (FULL_MASK)
    ) u_scanner (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (scan_start),
        .rdata  (bus.mem_rdata),
        .bitmap (scan_bitmap),
        .last   (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            op_rd_q     <= '0;
            row_ok_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            mem_re_q    <= mem_re_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            rf_we_q     <= rf_we_nxt;
            rf_waddr_q  <= rf_waddr_nxt;
            op_rd_q     <= op_rd_nxt;
            row_ok_q    <= row_ok_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        done_nxt      = 1'b0;
        mem_re_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        rf_we_nxt     = 1'b0;
        rf_waddr_nxt  = '0;
        op_rd_nxt     = op_rd_q;
        row_ok_nxt    = row_ok_q;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    op_rd_nxt  = bus.op_rd;
                    row_ok_nxt = row_in_range;
                    case (bus.op_type)
                        OP_GET_ROW: begin
                            state_nxt    = GET_RD;
                            mem_re_nxt   = row_in_range;
                            mem_addr_nxt = bus.op_row;
                        end
                        OP_SEND_ROW: begin
                            state_nxt     = SEND;
                            mem_we_nxt    = row_in_range;
                            mem_addr_nxt  = bus.op_row;
                            mem_wdata_nxt = bus.op_wdata;
                            done_nxt      = 1'b1;
                        end
                        OP_LINE_CHECK: begin
                            state_nxt    = SCAN;
                            mem_re_nxt   = 1'b1;
                            mem_addr_nxt = '0;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            GET_RD: begin
                state_nxt    = GET_WB;
                rf_we_nxt    = (op_rd_q != '0);
                rf_waddr_nxt = op_rd_q;
                done_nxt     = 1'b1;
            end
            SCAN: begin
                if (scan_last) begin
                    state_nxt    = LS_WB;
                    rf_we_nxt    = 1'b1;
                    rf_waddr_nxt = LINE_STATUS_REG;
                    done_nxt     = 1'b1;
                end else begin
                    mem_re_nxt   = 1'b1;
                    mem_addr_nxt = mem_addr_q + ADDR_W'(1);
                end
            end
            GET_WB, SEND, LS_WB: state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Write-back data is only known in the write-back cycle itself (RAM read latency).
    always_comb begin
        rf_wdata_c = '0;
        if (state == GET_WB && row_ok_q) rf_wdata_c = RF_DW'(bus.mem_rdata);
        else if (state == LS_WB)         rf_wdata_c = RF_DW'(scan_bitmap);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_c;
endmodule

// File: tb/tb_board_row_ctrl.sv
// Directed bench for board_row_ctrl: RAM model, scoreboard of expected RAM/RF/done events.
module tb_board_row_ctrl;
    import vetris_pkg::*;

    localparam int ROWS = 20;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } mem_ev_t;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_ev_t;

    logic        clk;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_idle = 0;
    logic [31:0] ram [32];
    logic [31:0] shadow [32];
    mem_ev_t     mem_q [$];
    rf_ev_t      rf_q [$];
    int          done_q [$];

    board_row_ctrl_if #(.ADDR_W(5), .ROW_W(32)) bus ();

    board_row_ctrl #(.ROWS(ROWS), .ROW_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port board RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re === 1'b1) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard consumer: every RAM strobe, RF write and done pulse must match the queue head.
    always @(negedge clk) begin
        mem_ev_t m;
        rf_ev_t  r;
        int      d;
        if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
            chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
            if (mem_q.size() == 0) begin
                chk("mem_unexpected", 32'({bus.mem_we, bus.mem_re}), 32'd0);
            end else begin
                m = mem_q.pop_front();
                chk("mem_cyc", 32'(cyc), 32'(m.cyc));
                chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
        if (bus.rf_we === 1'b1) begin
            if (rf_q.size() == 0) begin
                chk("rf_unexpected", 32'(bus.rf_we), 32'd0);
            end else begin
                r = rf_q.pop_front();
                chk("rf_cyc", 32'(cyc), 32'(r.cyc));
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(r.addr));
                chk("rf_wdata", bus.rf_wdata, r.data);
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'(bus.done), 32'd0);
            end else begin
                d = done_q.pop_front();
                chk("done_cyc", 32'(cyc), 32'(d));
            end
        end
    end

    // Bench model of one op accepted in cycle t.
    task automatic push_exp(input op_type_e op, input int row, input logic [31:0] wd,
                            input logic [4:0] rd, input int t);
        logic [31:0] bm;
        logic [31:0] data;
        case (op)
            OP_GET_ROW: begin
                data = 32'd0;
                if (row < ROWS) begin
                    mem_q.push_back('{t + 1, 1'b0, 5'(row), 32'd0});
                    data = shadow[row];
                end
                if (rd != 5'd0) rf_q.push_back('{t + 2, rd, data});
                done_q.push_back(t + 2);
                exp_idle = t + 3;
            end
            OP_SEND_ROW: begin
                if (row < ROWS) begin
                    mem_q.push_back('{t + 1, 1'b1, 5'(row), wd});
                    shadow[row] = wd;
                end
                done_q.push_back(t + 1);
                exp_idle = t + 2;
            end
            OP_LINE_CHECK: begin
                bm = 32'd0;
                for (int i = 0; i < ROWS; i++) begin
                    mem_q.push_back('{t + 1 + i, 1'b0, 5'(i), 32'd0});
                    if ((shadow[i] & 32'h3FF) == 32'h3FF) bm[i] = 1'b1;
                end
                rf_q.push_back('{t + ROWS + 1, 5'd9, bm});
                done_q.push_back(t + ROWS + 1);
                exp_idle = t + ROWS + 2;
            end
            default: exp_idle = t + 1;
        endcase
    endtask

    task automatic issue(input op_type_e op, input int row, input logic [31:0] wd, input logic [4:0] rd);
        chk("pre_busy", 32'(bus.busy), 32'd0);
        bus.op_valid = 1'b1;
        bus.op_type  = op;
        bus.op_row   = 5'(row);
        bus.op_wdata = wd;
        bus.op_rd    = rd;
        push_exp(op, row, wd, rd, cyc);
        tick();
        bus.op_valid = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), (op == OP_RSVD) ? 32'd0 : 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (bus.busy === 1'b0 && mem_q.size() == 0 && rf_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("idle_reached", 32'(ok), 32'd1);
        chk("idle_cycle", 32'(cyc), 32'(exp_idle));
    endtask

    initial begin
        int t;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_type  = OP_GET_ROW;
        bus.op_row   = '0;
        bus.op_wdata = '0;
        bus.op_rd    = '0;
        for (int i = 0; i < 32; i++) begin
            ram[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        ram[3] = 32'hABCD;  shadow[3] = 32'hABCD;
        ram[0] = 32'h3FF;   shadow[0] = 32'h3FF;
        ram[5] = 32'h3FF;   shadow[5] = 32'h3FF;
        ram[7] = 32'h3FE;   shadow[7] = 32'h3FE;

        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // getRow row 3 into $8.
        issue(OP_GET_ROW, 3, 32'd0, 5'd8);
        wait_idle();

        // sendRow row 19 then read it back into $12.
        issue(OP_SEND_ROW, 19, 32'h3FF, 5'd0);
        wait_idle();
        issue(OP_GET_ROW, 19, 32'd0, 5'd12);
        wait_idle();

        // lineCheck: rows 0, 5, 19 full; row 7 one bit short.
        issue(OP_LINE_CHECK, 0, 32'd0, 5'd0);
        wait_idle();
        chk("bitmap_model", shadow[19] & 32'h3FF, 32'h3FF);

        // Out-of-range rows, rd=0 suppression, reserved op.
        issue(OP_GET_ROW, 25, 32'd0, 5'd4);
        wait_idle();
        issue(OP_SEND_ROW, 31, 32'hDEAD, 5'd0);
        wait_idle();
        issue(OP_GET_ROW, 3, 32'd0, 5'd0);
        wait_idle();
        issue(OP_RSVD, 3, 32'd0, 5'd6);
        wait_idle();

        // op_valid held through a lineCheck: next op waits for the first IDLE cycle.
        t = cyc;
        bus.op_valid = 1'b1;
        bus.op_type  = OP_LINE_CHECK;
        push_exp(OP_LINE_CHECK, 0, 32'd0, 5'd0, t);
        tick();
        bus.op_type = OP_GET_ROW;
        bus.op_row  = 5'd0;
        bus.op_rd   = 5'd7;
        push_exp(OP_GET_ROW, 0, 32'd0, 5'd7, t + ROWS + 2);
        repeat (ROWS + 2) tick();
        chk("held_second_busy", 32'(bus.busy), 32'd1);
        bus.op_valid = 1'b0;
        wait_idle();

        // Reset while scanning row 10: bitmap discarded, no RF write.
        issue(OP_LINE_CHECK, 0, 32'd0, 5'd0);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        mem_q.delete();
        rf_q.delete();
        done_q.delete();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (25) tick();
        issue(OP_LINE_CHECK, 0, 32'd0, 5'd0);
        wait_idle();

        // Reset sampled in a sendRow accept cycle cancels the write.
        bus.op_valid = 1'b1;
        bus.op_type  = OP_SEND_ROW;
        bus.op_row   = 5'd2;
        bus.op_wdata = 32'h3FF;
        rst_n        = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        chk("acc_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("acc_rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();
        issue(OP_GET_ROW, 2, 32'd0, 5'd5);
        wait_idle();

        repeat (3) tick();
        chk("mem_q_left", 32'(mem_q.size()), 32'd0);
        chk("rf_q_left", 32'(rf_q.size()), 32'd0);
        chk("done_q_left", 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
